// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: boot loader state encoding and datapath widths.
package cpu_pkg;

    localparam int INSTR_W         = 26;
    localparam int PC_W            = 16;
    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERR
    } boot_state_t;

endpackage

// File: rtl/im_word_packer.sv
// Packs a big-endian byte stream into instruction words, pulsing word_done
// on the byte that completes a word.
module im_word_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_out,
    output logic               word_done
);

    logic [INSTR_W-1:0] shift_q, shift_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;

    // Shifting left drops the upper six bits of the first byte on their own.
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        word_done  = 1'b0;
        if (byte_valid) begin
            shift_d    = {shift_q[INSTR_W-9:0], byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_done  = (byte_cnt_q == 2'(BYTES_PER_INSTR - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word_out = shift_q;

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: receives a counted, checksummed program image over a byte
// handshake, writes it into instruction memory, then releases the CPU.
module im_boot_loader #(
    parameter int IM_DEPTH = 256,
    parameter int INSTR_W  = 26,
    parameter int ADDR_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         RX_Data,
    input  logic               RX_Valid,
    output logic               RX_Ready,
    output logic               IM_WE,
    output logic [ADDR_W-1:0]  IM_Addr,
    output logic [INSTR_W-1:0] IM_WData,
    output logic               START,
    output logic               Error
);

    import cpu_pkg::*;

    boot_state_t        state_q, state_d;
    logic [PC_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic [7:0]         csum_q, csum_d;
    logic               start_q, start_d;
    logic               error_q, error_d;
    logic               ready;
    logic               accept;
    logic               pack_valid;
    logic               word_done;
    logic [INSTR_W-1:0] packed_word;

    assign RX_Ready   = ready & ~RST;
    assign accept     = RX_Valid & RX_Ready;
    assign pack_valid = accept & (state_q == S_DATA);

    im_word_packer u_packer (
        .clk        (CLK),
        .rst        (RST),
        .byte_valid (pack_valid),
        .byte_in    (RX_Data),
        .word_out   (packed_word),
        .word_done  (word_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        ready      = 1'b0;
        unique case (state_q)
            S_CNT_HI: begin
                ready = 1'b1;
                if (accept) begin
                    count_d = {RX_Data, 8'h00};
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                ready = 1'b1;
                if (accept) begin
                    count_d = {count_q[PC_W-1:8], RX_Data};
                    if (int'(count_d) > IM_DEPTH) begin
                        state_d = S_ERR;
                    end else if (count_d == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ready = 1'b1;
                if (accept) begin
                    csum_d = csum_q ^ RX_Data;
                    if (word_done) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (word_idx_q == ADDR_W'(count_q - PC_W'(1))) begin
                    state_d = S_CSUM;
                end else begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    state_d    = S_DATA;
                end
            end
            S_CSUM: begin
                ready = 1'b1;
                if (accept) begin
                    state_d = (RX_Data == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_CNT_HI;
            end
        endcase
        start_d = (state_d == S_RUN);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_CNT_HI;
            count_q    <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            start_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            start_q    <= start_d;
            error_q    <= error_d;
        end
    end

    assign IM_WE    = (state_q == S_WRITE);
    assign IM_Addr  = word_idx_q;
    assign IM_WData = packed_word;
    assign START    = start_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: an image-level reference model
// predicts every handshake, IM write and final status cycle by cycle.
module tb_im_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        imWe;
    logic [15:0] imAddr;
    logic [25:0] imWData;
    logic        start;
    logic        error;

    int checks     = 0;
    int failures   = 0;
    int writeCount = 0;

    logic [25:0] imMem [0:255];
    logic [25:0] refWords [0:255];
    logic [7:0]  txQ [$];
    logic [7:0]  buildCsum;

    bit          modelValid = 1'b0;
    bit          expWe, expStart, expError, expReady;
    logic [15:0] expAddr;
    logic [25:0] expData;
    int unsigned mPos, mN;
    logic [7:0]  mHi, mCsum;
    logic [31:0] mWord;
    bit          mDone;

    always #5 clk = ~clk;

    im_boot_loader dut (
        .CLK      (clk),
        .RST      (rst),
        .RX_Data  (rxData),
        .RX_Valid (rxValid),
        .RX_Ready (rxReady),
        .IM_WE    (imWe),
        .IM_Addr  (imAddr),
        .IM_WData (imWData),
        .START    (start),
        .Error    (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Image position decides everything: 2 count bytes, 4N payload bytes, then the checksum.
    task modelByte(input logic [7:0] b);
        if (mPos == 0) begin
            mHi = b;
        end else if (mPos == 1) begin
            mN = 32'({mHi, b});
            if (mN > 256) begin
                mDone    = 1'b1;
                expError = 1'b1;
            end
        end else if (mPos < 2 + 4 * mN) begin
            mCsum = mCsum ^ b;
            mWord = {mWord[23:0], b};
            if ((mPos - 2) % 4 == 3) begin
                expWe   = 1'b1;
                expAddr = 16'((mPos - 2) / 4);
                expData = mWord[25:0];
            end
        end else begin
            mDone = 1'b1;
            if (b == mCsum) expStart = 1'b1;
            else            expError = 1'b1;
        end
        mPos++;
    endtask

    always @(negedge clk) begin
        bit accepted;
        if (modelValid) begin
            checkOutput("rx_ready", rxReady, expReady && !rst);
            checkOutput("im_we", imWe, expWe);
            if (expWe) begin
                checkOutput("im_addr", imAddr, expAddr);
                checkOutput("im_wdata", imWData, expData);
            end
            checkOutput("start", start, expStart);
            checkOutput("error", error, expError);
        end
        if (imWe === 1'b1) begin
            writeCount++;
            if (imAddr < 16'd256) imMem[imAddr[7:0]] = imWData;
        end
        if (rst) begin
            modelValid = 1'b1;
            expWe = 1'b0; expStart = 1'b0; expError = 1'b0; expReady = 1'b1;
            mPos = 0; mN = 0; mHi = 8'h00; mCsum = 8'h00; mWord = 32'h0; mDone = 1'b0;
        end else if (modelValid) begin
            accepted = rxValid && expReady;
            expWe    = 1'b0;
            if (accepted) modelByte(rxData);
            expReady = !mDone && !expWe;
        end
    end

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1'b1;
        rxValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rx_ready", rxReady, 0);
        checkOutput("reset_im_we", imWe, 0);
        checkOutput("reset_im_addr", imAddr, 0);
        checkOutput("reset_im_wdata", imWData, 0);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", rxReady, 1);
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        rxValid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic beginImage(input int n);
        txQ.delete();
        txQ.push_back(8'(n >> 8));
        txQ.push_back(8'(n));
        buildCsum = 8'h00;
    endtask

    task automatic addWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            txQ.push_back(w[8*i +: 8]);
            buildCsum = buildCsum ^ w[8*i +: 8];
        end
    endtask

    task automatic endImage(input logic [7:0] flip);
        txQ.push_back(buildCsum ^ flip);
    endtask

    // Drives txQ (optionally only its first maxBytes) with random idle gaps.
    task automatic applyStimulus(input int gapPct, input int maxBytes);
        int  total;
        int  waited;
        bit  acc;
        total = (maxBytes > 0 && maxBytes < txQ.size()) ? maxBytes : txQ.size();
        for (int i = 0; i < total; i++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < gapPct; g++) begin
                rxValid = 1'b0;
                rxData  = 8'($urandom);
                @(posedge clk); #1;
            end
            rxValid = 1'b1;
            rxData  = txQ[i];
            acc     = 1'b0;
            waited  = 0;
            while (!acc && waited < 100) begin
                @(negedge clk);
                acc = rxReady;
                @(posedge clk); #1;
                waited++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout byte=%0d actual=not_accepted expected=accepted", i);
                break;
            end
        end
        rxValid = 1'b0;
    endtask

    task automatic expectFinal(input string name, input bit expS, input bit expE);
        @(negedge clk);
        checkOutput({name, "_start"}, start, expS);
        checkOutput({name, "_error"}, error, expE);
        @(posedge clk); #1;
    endtask

    initial begin
        int w0;
        int n;
        bit bad;
        rst = 1'b1;
        rxValid = 1'b0;
        rxData = 8'h00;
        resetDut();

        $display("[TB] N=2 back-to-back image");
        w0 = writeCount;
        beginImage(2); addWord(32'h00000001); addWord(32'h03FFFFFF); endImage(8'h00);
        applyStimulus(0, 0);
        expectFinal("n2_good", 1'b1, 1'b0);
        checkOutput("n2_word0", imMem[0], 26'h0000001);
        checkOutput("n2_word1", imMem[1], 26'h3FFFFFF);
        checkOutput("n2_writes", writeCount - w0, 2);

        $display("[TB] N=2 image with checksum 0x04");
        resetDut();
        w0 = writeCount;
        beginImage(2); addWord(32'h00000001); addWord(32'h03FFFFFF); txQ.push_back(8'h04);
        applyStimulus(0, 0);
        expectFinal("n2_bad", 1'b0, 1'b1);
        checkOutput("n2_bad_writes", writeCount - w0, 2);
        rxValid = 1'b1;
        rxData  = 8'hAA;
        repeat (4) begin
            @(negedge clk);
            checkOutput("ready_after_error", rxReady, 0);
            @(posedge clk); #1;
        end
        rxValid = 1'b0;

        $display("[TB] N=0 images");
        resetDut();
        w0 = writeCount;
        beginImage(0); endImage(8'h00);
        applyStimulus(0, 0);
        expectFinal("n0_good", 1'b1, 1'b0);
        checkOutput("n0_writes", writeCount - w0, 0);
        resetDut();
        beginImage(0); endImage(8'h01);
        applyStimulus(0, 0);
        expectFinal("n0_bad", 1'b0, 1'b1);

        $display("[TB] count above depth");
        resetDut();
        w0 = writeCount;
        beginImage(257);
        applyStimulus(0, 0);
        expectFinal("oversize", 1'b0, 1'b1);
        checkOutput("oversize_writes", writeCount - w0, 0);

        $display("[TB] N=2 image with random valid gaps");
        resetDut();
        imMem[0] = '0;
        imMem[1] = '0;
        beginImage(2); addWord(32'h00000001); addWord(32'h03FFFFFF); endImage(8'h00);
        applyStimulus(60, 0);
        expectFinal("gapped", 1'b1, 1'b0);
        checkOutput("gapped_word0", imMem[0], 26'h0000001);
        checkOutput("gapped_word1", imMem[1], 26'h3FFFFFF);

        $display("[TB] discarded upper bits of b0");
        resetDut();
        txQ.delete();
        txQ = '{8'h00, 8'h01, 8'hFC, 8'h12, 8'h34, 8'h56, 8'h8C};
        applyStimulus(30, 0);
        expectFinal("fc", 1'b1, 1'b0);
        checkOutput("fc_word", imMem[0], 26'h0123456);
        checkOutput("fc_top_bits", imMem[0][25:24], 2'b00);

        $display("[TB] random images");
        for (int r = 0; r < 6; r++) begin
            resetDut();
            n   = $urandom_range(1, 8);
            bad = ($urandom_range(0, 2) == 0);
            beginImage(n);
            for (int k = 0; k < n; k++) addWord($urandom);
            endImage(bad ? 8'h5A : 8'h00);
            applyStimulus(40, 0);
            expectFinal("random", !bad, bad);
        end

        $display("[TB] full-depth image");
        resetDut();
        w0 = writeCount;
        beginImage(256);
        for (int k = 0; k < 256; k++) begin
            logic [31:0] w;
            w = $urandom;
            refWords[k] = w[25:0];
            addWord(w);
        end
        endImage(8'h00);
        applyStimulus(0, 0);
        expectFinal("depth", 1'b1, 1'b0);
        checkOutput("depth_writes", writeCount - w0, 256);
        for (int k = 0; k < 256; k++) begin
            checkOutput("depth_word", imMem[k], refWords[k]);
        end

        $display("[TB] reset in the middle of word 1");
        resetDut();
        imMem[1] = 26'h0;
        w0 = writeCount;
        beginImage(2); addWord(32'h01234567); addWord(32'h0089ABCD); endImage(8'h00);
        applyStimulus(0, 8);
        idleCycles(2);
        checkOutput("partial_writes", writeCount - w0, 1);
        resetDut();
        idleCycles(3);
        checkOutput("partial_after_reset_writes", writeCount - w0, 1);
        checkOutput("partial_word_untouched", imMem[1], 26'h0);
        beginImage(1); addWord(32'h02AAAAAA); endImage(8'h00);
        applyStimulus(20, 0);
        expectFinal("reload", 1'b1, 1'b0);
        checkOutput("reload_word0", imMem[0], 26'h2AAAAAA);
        checkOutput("reload_writes", writeCount - w0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
